// File: rtl/beaker8_pkg.sv
// Shared types and constants for the Beaker8 instruction-byte prefetcher.
package beaker8_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef enum logic {
        PF_FETCH = 1'b0,
        PF_HALT  = 1'b1
    } pf_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [7:0]        data;
    } pf_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH-entry synchronous queue of {pc, data} with flush and a registered head
// that holds its last value once the queue runs empty.
module prefetch_fifo
    import beaker8_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  pf_entry_t              push_entry,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output pf_entry_t              head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    pf_entry_t              mem_q [DEPTH];
    pf_entry_t              mem_d [DEPTH];
    logic      [PTR_W-1:0]  wr_q, wr_d;
    logic      [PTR_W-1:0]  rd_q, rd_d;
    logic      [CNT_W-1:0]  cnt_q, cnt_d;
    pf_entry_t              head_q, head_d;
    logic                   pop_ok;
    logic                   push_ok;
    logic      [CNT_W-1:0]  left;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        pop_ok  = pop && (cnt_q != '0);
        push_ok = push && ((cnt_q != CNT_W'(DEPTH)) || pop_ok);
        left    = cnt_q - CNT_W'(pop_ok);
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_q] = push_entry;
                wr_d        = wr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_d = rd_q + PTR_W'(1);
            end
            cnt_d = left + CNT_W'(push_ok);
            // Next head is the fresh byte only when nothing older survives the pop.
            if (cnt_d != '0) begin
                head_d = (left == '0) ? push_entry : mem_q[rd_d];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q  <= '{default: '0};
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    assign count = cnt_q;
    assign head  = head_q;

endmodule

// File: rtl/rom_prefetch.sv
// Boot-ROM instruction-byte prefetcher: issues ROM fetches, queues PC-tagged
// bytes for the decoder, and handles redirects, halt and bus loss.
module rom_prefetch
    import beaker8_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              rom_cs,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              bus_grant,
    output logic              q_valid,
    output logic [7:0]        q_data,
    output logic [ADDR_W-1:0] q_pc,
    input  logic              q_pop,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              halt_req,
    output logic              halted
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    pf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  count;
    pf_entry_t         head;
    pf_entry_t         push_entry;
    logic              full;
    logic              fifo_pop;

    assign full       = (count == CNT_W'(DEPTH));
    assign q_valid    = (count != '0);
    assign fifo_pop   = q_pop && q_valid && !jump_valid;
    assign push_entry = '{pc: fetch_pc_q, data: rom_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= PF_FETCH;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PF_FETCH: if (halt_req) state_d = PF_HALT;
            PF_HALT:  if (!halt_req || jump_valid) state_d = PF_FETCH;
            default:  state_d = PF_FETCH;
        endcase
    end

    // rom_cs is held low throughout reset so no fetch escapes while the core is held.
    always_comb begin
        rom_cs = 1'b0;
        halted = (state_q == PF_HALT);
        if ((state_q == PF_FETCH) && !reset && bus_grant && !jump_valid &&
            (!full || (q_pop && q_valid))) begin
            rom_cs = 1'b1;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (jump_valid) begin
            fetch_pc_d = jump_addr;
        end else if (rom_cs) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (rom_cs),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .flush      (jump_valid),
        .count      (count),
        .head       (head)
    );

    assign rom_addr = fetch_pc_q;
    assign q_data   = head.data;
    assign q_pc     = head.pc;

endmodule

// File: tb/tb_rom_prefetch.sv
// Randomized self-checking bench for rom_prefetch against a queue-based model.
module tb_rom_prefetch;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [13:0] pc;
        logic [7:0]  data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rom_cs;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data;
    logic        bus_grant = 1'b0;
    logic        q_valid;
    logic [7:0]  q_data;
    logic [13:0] q_pc;
    logic        q_pop = 1'b0;
    logic        jump_valid = 1'b0;
    logic [13:0] jump_addr = '0;
    logic        halt_req = 1'b0;
    logic        halted;

    logic [7:0]  rom [0:16383];
    int          tests = 0;
    int          fails = 0;

    ent_t        mq[$];
    logic [13:0] pc_m;
    logic        halted_m;
    ent_t        last_m;

    rom_prefetch #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .bus_grant  (bus_grant),
        .q_valid    (q_valid),
        .q_data     (q_data),
        .q_pc       (q_pc),
        .q_pop      (q_pop),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr),
        .halt_req   (halt_req),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    assign rom_data = rom_cs ? rom[rom_addr] : 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic exp_cs();
        return !reset && !halted_m && bus_grant && !jump_valid &&
               ((mq.size() < DEPTH) || (q_pop && mq.size() > 0));
    endfunction

    // Reference model: a plain queue of {pc,data} updated at each clock edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            pc_m     = 14'h0;
            halted_m = 1'b0;
            last_m   = '0;
        end else begin
            logic fire;
            fire = exp_cs();
            if (jump_valid) begin
                mq.delete();
                pc_m = jump_addr;
            end else begin
                if (q_pop && mq.size() > 0) void'(mq.pop_front());
                if (fire) begin
                    mq.push_back('{pc: pc_m, data: rom[pc_m]});
                    pc_m = pc_m + 14'd1;
                end
            end
            halted_m = halted_m ? (halt_req && !jump_valid) : halt_req;
            if (mq.size() > 0) last_m = mq[0];
        end
    end

    always @(negedge clk) begin
        ent_t h;
        h = (mq.size() > 0) ? mq[0] : last_m;
        chk("m_valid", 32'(q_valid), 32'(mq.size() > 0));
        chk("m_data", 32'(q_data), 32'(h.data));
        chk("m_pc", 32'(q_pc), 32'(h.pc));
        chk("m_addr", 32'(rom_addr), 32'(pc_m));
        chk("m_halted", 32'(halted), 32'(halted_m));
        chk("m_cs", 32'(rom_cs), 32'(exp_cs()));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  t1_data [5];
        logic [13:0] t4_pc [4];
        logic        t5_pat [4];
        int          cs_cnt;
        int          got;

        t1_data = '{8'hF3, 8'h10, 8'h05, 8'h00, 8'h00};
        t4_pc   = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        t5_pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 16384; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) rom[i] = t1_data[i];
        rom[16'h0010] = 8'hA5;

        repeat (2) cyc();
        bus_grant = 1'b1;
        #1;
        chk("rst_cs", 32'(rom_cs), 32'h0);
        chk("rst_valid", 32'(q_valid), 32'h0);
        chk("rst_data", 32'(q_data), 32'h0);
        chk("rst_pc", 32'(q_pc), 32'h0);
        chk("rst_addr", 32'(rom_addr), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);

        // Fill from reset with no pops: four fetches at 0..3, then stall.
        cyc();
        reset = 1'b0;
        cs_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (rom_cs) begin
                chk("t1_addr", 32'(rom_addr), 32'(cs_cnt));
                cs_cnt++;
            end
            cyc();
        end
        chk("t1_cs_count", 32'(cs_cnt), 32'd4);
        #1;
        chk("t1_data", 32'(q_data), 32'hF3);
        chk("t1_pc", 32'(q_pc), 32'h0);

        // Continuous pop from full.
        q_pop = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t2_valid", 32'(q_valid), 32'h1);
            chk("t2_data", 32'(q_data), 32'(t1_data[k]));
            chk("t2_pc", 32'(q_pc), 32'(k));
            cyc();
        end

        // Drop to three entries, then redirect to 0x0010.
        bus_grant = 1'b0;
        cyc();
        q_pop = 1'b0;
        bus_grant = 1'b1;
        jump_valid = 1'b1;
        jump_addr = 14'h0010;
        cyc();
        jump_valid = 1'b0;
        #1;
        chk("t3_valid0", 32'(q_valid), 32'h0);
        chk("t3_addr", 32'(rom_addr), 32'h10);
        chk("t3_cs", 32'(rom_cs), 32'h1);
        cyc();
        #1;
        chk("t3_valid1", 32'(q_valid), 32'h1);
        chk("t3_data", 32'(q_data), 32'hA5);
        chk("t3_pc", 32'(q_pc), 32'h10);

        // Redirect near the top of the ROM and watch the PC wrap.
        jump_valid = 1'b1;
        jump_addr = 14'h3FFE;
        q_pop = 1'b1;
        cyc();
        jump_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && got < 4; i++) begin
            #1;
            if (q_valid) begin
                chk("t4_pc", 32'(q_pc), 32'(t4_pc[got]));
                got++;
            end
            cyc();
        end
        chk("t4_count", 32'(got), 32'd4);

        // Bus lost for two cycles while popping.
        for (int i = 0; i < 4; i++) begin
            bus_grant = t5_pat[i];
            #1;
            if (!t5_pat[i]) chk("t5_cs", 32'(rom_cs), 32'h0);
            cyc();
        end
        bus_grant = 1'b1;
        repeat (4) cyc();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bus_grant  = ($urandom_range(0, 3) != 0);
            q_pop      = ($urandom_range(0, 2) != 0);
            jump_valid = ($urandom_range(0, 15) == 0);
            jump_addr  = 14'($urandom);
            if ($urandom_range(0, 24) == 0) halt_req = ~halt_req;
            cyc();
        end
        halt_req = 1'b0;
        jump_valid = 1'b0;
        q_pop = 1'b0;
        bus_grant = 1'b1;
        repeat (6) cyc();

        // Halt mid-stream, drain, then redirect out of HALT.
        halt_req = 1'b1;
        q_pop = 1'b1;
        cyc();
        #1;
        chk("t6_halted", 32'(halted), 32'h1);
        chk("t6_cs", 32'(rom_cs), 32'h0);
        chk("t6_valid", 32'(q_valid), 32'h1);
        repeat (2) cyc();
        jump_valid = 1'b1;
        jump_addr = 14'h0003;
        halt_req = 1'b0;
        cyc();
        jump_valid = 1'b0;
        #1;
        chk("t6_unhalt", 32'(halted), 32'h0);
        chk("t6_fetch_cs", 32'(rom_cs), 32'h1);
        chk("t6_fetch_addr", 32'(rom_addr), 32'h3);
        q_pop = 1'b0;
        cyc();
        cyc();
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_cs", 32'(rom_cs), 32'h0);
        chk("t6_rst_valid", 32'(q_valid), 32'h0);
        chk("t6_rst_data", 32'(q_data), 32'h0);
        chk("t6_rst_pc", 32'(q_pc), 32'h0);
        chk("t6_rst_addr", 32'(rom_addr), 32'h0);
        chk("t6_rst_halted", 32'(halted), 32'h0);
        cyc();
        reset = 1'b0;
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
